// File: rtl/traffic_sensor_model_if.sv
// traffic_sensor_model_if: light, arrival and sensor/status signals between a
// light controller (master) and the intersection sensor model (slave).
interface traffic_sensor_model_if #(
   parameter int QW = 4
);
   logic          ARR_A, ARR_B;
   logic          LA1, LA0, LB1, LB0;
   logic          TA, TB;
   logic [QW-1:0] QA, QB;
   logic          OVF_A, OVF_B;
   logic          ERR;
   logic [1:0]    ERR_CODE;
   modport master (
      output ARR_A, ARR_B, LA1, LA0, LB1, LB0,
      input  TA, TB, QA, QB, OVF_A, OVF_B, ERR, ERR_CODE
   );
   modport slave (
      input  ARR_A, ARR_B, LA1, LA0, LB1, LB0,
      output TA, TB, QA, QB, OVF_A, OVF_B, ERR, ERR_CODE
   );
endinterface

// File: rtl/traffic_sensor_model.sv
// traffic_sensor_model: per-street vehicle queues driving the TA/TB car sensors
// from the controller's lights, plus a sticky light-sequence checker.
module traffic_sensor_model #(
   parameter int QW      = 4,
   parameter int DEP_CYC = 2
) (
   input logic                   CLK,
   input logic                   RESETB,
   traffic_sensor_model_if.slave bus
);
   localparam logic [1:0]    G = 2'b00, Y = 2'b01, R = 2'b10, X = 2'b11;
   localparam logic [QW-1:0] QMAX = '1;
   localparam logic [3:0]    DEP_LAST = 4'(DEP_CYC - 1);
   logic [1:0][1:0]    lt, prev;
   logic [1:0][QW-1:0] qv;
   logic [1:0]         arr, ov, bad_tr;
   logic               err, enc_bad, conflict;
   logic [1:0]         err_code, code;
   assign lt  = {{bus.LB1, bus.LB0}, {bus.LA1, bus.LA0}};
   assign arr = {bus.ARR_B, bus.ARR_A};
   for (genvar s = 0; s < 2; s++) begin : g_st
      logic [QW-1:0] q;
      logic [3:0]    tmr;
      logic          busy, run, dep, ovf;
      assign busy = |q;
      assign run  = lt[s] == G && busy;
      assign dep  = run && tmr == DEP_LAST;
      // a previous light of 11 was already reported as an encoding error
      assign bad_tr[s] = prev[s] != X &&
                         !(lt[s] == prev[s] ||
                           (prev[s] == G && lt[s] == Y) ||
                           (prev[s] == Y && lt[s] == R) ||
                           (prev[s] == R && lt[s] == G));
      always_ff @(posedge CLK or negedge RESETB)
         if (!RESETB) begin
            q   <= '0;
            tmr <= '0;
            ovf <= 1'b0;
         end else begin
            tmr <= run && !dep ? tmr + 4'd1 : 4'd0;
            q   <= arr[s] && !dep ? (q == QMAX ? q : q + 1'b1) :
                   dep && !arr[s] ? q - 1'b1 : q;
            ovf <= ovf | (arr[s] && !dep && q == QMAX);
         end
      assign qv[s] = q;
      assign ov[s] = ovf;
   end
   assign enc_bad  = lt[0] == X || lt[1] == X;
   assign conflict = lt[0] != R && lt[1] != R;
   assign code     = enc_bad ? 2'b01 : conflict ? 2'b10 : |bad_tr ? 2'b11 : 2'b00;
   always_ff @(posedge CLK or negedge RESETB)
      if (!RESETB) begin
         prev     <= {R, R};
         err      <= 1'b0;
         err_code <= 2'b00;
      end else begin
         prev <= lt;
         if (!err && |code) begin
            err      <= 1'b1;
            err_code <= code;
         end
      end
   assign bus.QA       = qv[0];
   assign bus.QB       = qv[1];
   assign bus.TA       = |qv[0];
   assign bus.TB       = |qv[1];
   assign bus.OVF_A    = ov[0];
   assign bus.OVF_B    = ov[1];
   assign bus.ERR      = err;
   assign bus.ERR_CODE = err_code;
endmodule

// File: tb/tb_traffic_sensor_model.sv
// tb_traffic_sensor_model: random and directed light/arrival stimulus against a
// queue-and-rules reference model, checked through a scoreboard queue.
module tb_traffic_sensor_model;
   localparam int QW = 4, DEP_CYC = 2, QMAX = (1 << QW) - 1;
   localparam bit [1:0] G = 2'd0, Y = 2'd1, R = 2'd2, X = 2'd3;
   typedef struct packed {
      logic          ta, tb;
      logic [QW-1:0] qa, qb;
      logic          oa, ob, err;
      logic [1:0]    code;
   } exp_t;
   logic CLK = 1'b0, RESETB = 1'b1;
   exp_t sb[$];
   int n_chk = 0, n_fail = 0;
   int mq[2], mrun[2];
   bit movf[2], merr;
   bit [1:0] mcode, mprev[2];
   int phase = 0, dwell = 0, lim = 3;
   bit [1:0] la_t[4] = '{G, Y, R, R};
   bit [1:0] lb_t[4] = '{R, R, G, Y};
   traffic_sensor_model_if #(.QW(QW)) bus ();
   traffic_sensor_model #(.QW(QW), .DEP_CYC(DEP_CYC)) dut (
      .CLK(CLK), .RESETB(RESETB), .bus(bus)
   );
   always #5 CLK = ~CLK;
   // colours cycle G(0) -> Y(1) -> R(2) -> G; holding is always legal
   function automatic bit step_ok(input bit [1:0] p, input bit [1:0] c);
      return c == p || int'(c) == (int'(p) + 1) % 3;
   endfunction
   function automatic exp_t snap();
      exp_t e;
      e.ta = mq[0] != 0;
      e.tb = mq[1] != 0;
      e.qa = QW'(mq[0]);
      e.qb = QW'(mq[1]);
      e.oa = movf[0];
      e.ob = movf[1];
      e.err = merr;
      e.code = mcode;
      return e;
   endfunction
   task automatic chk(input string n, input logic [7:0] act, input logic [7:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", n, act, exp, $time);
      end
   endtask
   task automatic cyc(input bit aa, input bit ab, input bit [1:0] a, input bit [1:0] b);
      bit [1:0] lt[2];
      bit ar[2];
      bit [1:0] code;
      bit dep;
      {bus.ARR_A, bus.ARR_B, bus.LA1, bus.LA0, bus.LB1, bus.LB0} = {aa, ab, a, b};
      lt = '{a, b};
      ar = '{aa, ab};
      code = (a == X || b == X) ? 2'd1 : (a != R && b != R) ? 2'd2 :
             ((mprev[0] != X && !step_ok(mprev[0], a)) ||
              (mprev[1] != X && !step_ok(mprev[1], b))) ? 2'd3 : 2'd0;
      for (int s = 0; s < 2; s++) begin
         dep = 1'b0;
         if (lt[s] == G && mq[s] > 0) begin
            mrun[s]++;
            if (mrun[s] == DEP_CYC) begin
               dep = 1'b1;
               mrun[s] = 0;
            end
         end else mrun[s] = 0;
         if (ar[s] && !dep) begin
            if (mq[s] == QMAX) movf[s] = 1'b1;
            else mq[s]++;
         end else if (dep && !ar[s]) mq[s]--;
      end
      if (!merr && code != 0) begin
         merr = 1'b1;
         mcode = code;
      end
      mprev = '{a, b};
      sb.push_back(snap());
      @(negedge CLK);
   endtask
   // called at a falling clock edge; checked once asynchronously and once at the held edge
   task automatic do_reset();
      mq = '{0, 0};
      mrun = '{0, 0};
      movf = '{1'b0, 1'b0};
      merr = 1'b0;
      mcode = 2'd0;
      mprev = '{R, R};
      phase = 0;
      dwell = 0;
      sb.push_back(snap());
      sb.push_back(snap());
      RESETB = 1'b0;
      @(negedge CLK);
      RESETB = 1'b1;
   endtask
   task automatic legal_run(input int n, input int p_arr);
      for (int i = 0; i < n; i++) begin
         cyc($urandom_range(0, 99) < p_arr, $urandom_range(0, 99) < p_arr,
             la_t[phase], lb_t[phase]);
         if (++dwell >= lim) begin
            phase = (phase + 1) % 4;
            dwell = 0;
            lim = $urandom_range(1, 6);
         end
      end
   endtask
   initial begin
      exp_t e;
      forever begin
         @(posedge CLK or negedge RESETB);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("TA", 8'(bus.TA), 8'(e.ta));
            chk("TB", 8'(bus.TB), 8'(e.tb));
            chk("QA", 8'(bus.QA), 8'(e.qa));
            chk("QB", 8'(bus.QB), 8'(e.qb));
            chk("OVF_A", 8'(bus.OVF_A), 8'(e.oa));
            chk("OVF_B", 8'(bus.OVF_B), 8'(e.ob));
            chk("ERR", 8'(bus.ERR), 8'(e.err));
            chk("ERR_CODE", 8'(bus.ERR_CODE), 8'(e.code));
         end
      end
   end
   initial begin
      {bus.ARR_A, bus.ARR_B, bus.LA1, bus.LA0, bus.LB1, bus.LB0} = {2'b00, R, R};
      @(negedge CLK);
      do_reset();
      for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, G, R);
      for (int i = 0; i < 8; i++) cyc(1'b0, 1'b0, G, R);
      legal_run(150, 40);
      do_reset();
      for (int i = 0; i < 20; i++) cyc(1'b0, 1'b1, G, R);
      do_reset();
      for (int i = 0; i < 15; i++) cyc(1'b1, 1'b0, R, R);
      for (int i = 0; i < 12; i++) cyc(i % 2 == 1, 1'b0, G, R);
      do_reset();
      cyc(1'b0, 1'b0, G, R);
      cyc(1'b0, 1'b0, G, G);
      cyc(1'b0, 1'b0, X, R);
      cyc(1'b0, 1'b0, R, R);
      do_reset();
      cyc(1'b0, 1'b0, G, R);
      cyc(1'b0, 1'b0, R, R);
      cyc(1'b0, 1'b0, R, R);
      do_reset();
      cyc(1'b0, 1'b0, X, X);
      cyc(1'b0, 1'b0, R, R);
      do_reset();
      legal_run(30, 70);
      do_reset();
      legal_run(60, 50);
      for (int k = 0; k < 10; k++) begin
         do_reset();
         for (int i = 0; i < 15; i++)
            cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
      end
      @(negedge CLK);
      chk("sb_drained", 8'(sb.size()), 8'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
